// File: rtl/pe_arr_feeder_if.sv
// Bundle between the tile controller / K-slice source and pe_arr_feeder.
// It carries the tile start, the valid/ready beat stream and the skewed array-edge lanes.
interface pe_arr_feeder_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int KMAX = 256
);
    localparam int KW = $clog2(KMAX + 1);

    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 s_valid;
    logic                 s_ready;
    logic [COLS-1:0][7:0] s_w;
    logic [ROWS-1:0][7:0] s_a;
    logic [COLS-1:0][7:0] out_w;
    logic [ROWS-1:0][7:0] out_a;
    logic                 fire;
    logic                 busy;
    logic                 done;

    modport master (
        output start, k_len, s_valid, s_w, s_a,
        input  s_ready, out_w, out_a, fire, busy, done
    );

    modport slave (
        input  start, k_len, s_valid, s_w, s_a,
        output s_ready, out_w, out_a, fire, busy, done
    );
endinterface

// File: rtl/pe_arr_feeder.sv
// pe_arr_feeder: accepts K-slices over valid/ready and skews them onto the PE_ARR edges.
// Build macro FEEDER_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module pe_arr_feeder #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int KMAX = 256
) (
    input  logic           clk,
    input  logic           rst,
`ifdef FEEDER_STALL_CNT_EN
    output logic [15:0]    stall_cnt,
`endif
    pe_arr_feeder_if.slave bus
);
    localparam int KW = $clog2(KMAX + 1);
    localparam int D  = ((ROWS > COLS) ? ROWS : COLS) - 1;
    localparam int FW = $clog2(D + 2);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [KW-1:0] beat_cnt_q, beat_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          fire_q, fire_d;
    logic          accept;

    assign accept = (state_q == STREAM) && bus.s_valid;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = flush_cnt_q;
        fire_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_len_d    = bus.k_len;
                    beat_cnt_d = '0;
                    state_d    = (bus.k_len == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    fire_d     = (beat_cnt_q == '0);
                    beat_cnt_d = beat_cnt_q + KW'(1);
                    if (beat_cnt_q == k_len_q - KW'(1)) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            // The last beat needs D more cycles to reach the deepest lane.
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + FW'(1);
                if (flush_cnt_q == FW'(D)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            fire_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            fire_q      <= fire_d;
        end
    end

    assign bus.s_ready = (state_q == STREAM);
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.fire    = fire_q;

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && bus.start) begin
            stall_cnt_d = '0;
        end else if ((state_q == STREAM) && !bus.s_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    // Bubbles and flush cycles push zero slices so the MACs see no contribution.
    logic [COLS-1:0][7:0] slice_w;
    logic [ROWS-1:0][7:0] slice_a;
    logic [7:0]           lane_w [COLS];
    logic [7:0]           lane_a [ROWS];

    assign slice_w = accept ? bus.s_w : '0;
    assign slice_a = accept ? bus.s_a : '0;

    for (genvar j = 0; j < COLS; j++) begin : g_w_lane
        logic [7:0] chain_q [j+1];
        logic [7:0] chain_d [j+1];

        always_comb begin
            chain_d[0] = slice_w[j];
            for (int k = 1; k <= j; k++) begin
                chain_d[k] = chain_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) begin
                    chain_q[k] <= '0;
                end
            end else begin
                chain_q <= chain_d;
            end
        end

        assign lane_w[j] = chain_q[j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
        logic [7:0] chain_q [i+1];
        logic [7:0] chain_d [i+1];

        always_comb begin
            chain_d[0] = slice_a[i];
            for (int k = 1; k <= i; k++) begin
                chain_d[k] = chain_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    chain_q[k] <= '0;
                end
            end else begin
                chain_q <= chain_d;
            end
        end

        assign lane_a[i] = chain_q[i];
    end

    always_comb begin
        bus.out_w = '0;
        bus.out_a = '0;
        for (int j = 0; j < COLS; j++) begin
            bus.out_w[j] = lane_w[j];
        end
        for (int i = 0; i < ROWS; i++) begin
            bus.out_a[i] = lane_a[i];
        end
    end
endmodule

// File: tb/tb_pe_arr_feeder.sv
// Bench for pe_arr_feeder (ROWS=2, COLS=6, so D=5) against a cycle-indexed beat history model.
// Build with FEEDER_STALL_CNT_EN defined to also check stall_cnt.
module tb_pe_arr_feeder;
    localparam int ROWS = 2;
    localparam int COLS = 6;
    localparam int KMAX = 16;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int D    = 5;
    localparam int NCYC = 8192;
    localparam int VW   = 4 + 8 * COLS + 8 * ROWS;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    pe_arr_feeder_if #(.ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)) bus ();

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pe_arr_feeder #(.ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)) dut (
        .clk       (clk),
`ifdef FEEDER_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .rst       (rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a beat accepted in cycle c shows on lane n in cycle c+1+n.
    int  cyc          = 0;
    int  m_phase      = 0;
    int  m_left       = 0;
    int  m_first      = 0;
    int  m_done_at    = -1;
    int  m_fire_at    = -1;
    int  m_clear_from = 0;
    int  m_stall      = 0;
    int  idx;
    bit [COLS-1:0][7:0] hist_w [NCYC];
    bit [ROWS-1:0][7:0] hist_a [NCYC];
    logic                 exp_ready = 1'b0;
    logic                 exp_busy  = 1'b0;
    logic                 exp_fire  = 1'b0;
    logic                 exp_done  = 1'b0;
    logic [15:0]          exp_stall = '0;
    logic [COLS-1:0][7:0] exp_w     = '0;
    logic [ROWS-1:0][7:0] exp_a     = '0;
    logic [VW-1:0]        obs_vec;
    logic [VW-1:0]        exp_vec;

    assign obs_vec = {bus.s_ready, bus.busy, bus.fire, bus.done, bus.out_w, bus.out_a};
    assign exp_vec = {exp_ready, exp_busy, exp_fire, exp_done, exp_w, exp_a};

    always @(posedge clk) begin
        if (rst) begin
            m_phase      = 0;
            m_done_at    = -1;
            m_fire_at    = -1;
            m_stall      = 0;
            m_clear_from = cyc + 1;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_stall = 0;
                    if (bus.k_len == '0) begin
                        m_phase   = 2;
                        m_done_at = cyc + 1;
                    end else begin
                        m_phase = 1;
                        m_left  = int'(bus.k_len);
                        m_first = 1;
                    end
                end
                1: if (bus.s_valid) begin
                    hist_w[cyc % NCYC] = bus.s_w;
                    hist_a[cyc % NCYC] = bus.s_a;
                    if (m_first != 0) m_fire_at = cyc + 1;
                    m_first = 0;
                    m_left  = m_left - 1;
                    if (m_left == 0) begin
                        m_phase   = 2;
                        m_done_at = cyc + 2 + D;
                    end
                end else if (m_stall < 65535) begin
                    m_stall = m_stall + 1;
                end
                default: if (cyc == m_done_at) m_phase = 0;
            endcase
        end
        cyc = cyc + 1;
        exp_ready = (m_phase == 1);
        exp_busy  = (m_phase != 0);
        exp_done  = (cyc == m_done_at);
        exp_fire  = (cyc == m_fire_at);
        exp_stall = 16'(m_stall);
        for (int j = 0; j < COLS; j++) begin
            idx = cyc - 1 - j;
            exp_w[j] = (idx >= 0 && idx >= m_clear_from) ? hist_w[idx % NCYC][j] : 8'h00;
        end
        for (int i = 0; i < ROWS; i++) begin
            idx = cyc - 1 - i;
            exp_a[i] = (idx >= 0 && idx >= m_clear_from) ? hist_a[idx % NCYC][i] : 8'h00;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.s_ready, bus.busy, bus.fire, bus.done} !== 4'b0000)
            $display("[TB] FAIL reset_ctrl got=%b exp=0000", {bus.s_ready, bus.busy, bus.fire, bus.done});
        else n_pass++;
        n_checks++;
        if ({bus.out_w, bus.out_a} !== {(8*COLS+8*ROWS){1'b0}})
            $display("[TB] FAIL reset_lanes got=%h exp=0", {bus.out_w, bus.out_a});
        else n_pass++;
`ifdef FEEDER_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd0) $display("[TB] FAIL reset_stall got=%0d exp=0", stall_cnt);
        else n_pass++;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int s, b, fire_seen, done_seen;
        s = cyc; b = 0; fire_seen = -1; done_seen = -1;
        for (int t = 0; t < 16; t++) begin
            bus.start   = (t == 0);
            bus.k_len   = KW'(3);
            bus.s_valid = 1'b1;
            bus.s_w     = {COLS{8'(b + 1)}};
            bus.s_a     = {ROWS{8'(b + 1)}};
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("[TB] FAIL basic cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (bus.fire === 1'b1 && fire_seen < 0) fire_seen = cyc;
            if (bus.done === 1'b1 && done_seen < 0) done_seen = cyc;
            if (exp_ready && bus.s_valid) b++;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        n_checks++;
        if (fire_seen !== s + 2) $display("[TB] FAIL basic_fire got=%0d exp=%0d", fire_seen, s + 2);
        else n_pass++;
        n_checks++;
        if (done_seen !== s + 10) $display("[TB] FAIL basic_done got=%0d exp=%0d", done_seen, s + 10);
        else n_pass++;
    endtask

    task automatic test_bubble();
        int s, b, done_seen;
        logic [7:0] l0 [16];
        logic [7:0] want [4] = '{8'd1, 8'd0, 8'd2, 8'd3};
        s = cyc; b = 0; done_seen = -1;
        for (int t = 0; t < 16; t++) begin
            bus.start   = (t == 0);
            bus.k_len   = KW'(3);
            bus.s_valid = (t != 2);
            bus.s_w     = {COLS{8'(b + 1)}};
            bus.s_a     = {ROWS{8'(b + 1)}};
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("[TB] FAIL bubble cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            l0[t] = bus.out_w[0];
            if (bus.done === 1'b1 && done_seen < 0) done_seen = cyc;
            if (exp_ready && bus.s_valid) b++;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (l0[k + 2] !== want[k]) $display("[TB] FAIL bubble_lane0[%0d] got=%h exp=%h", k, l0[k + 2], want[k]);
            else n_pass++;
        end
        n_checks++;
        if (done_seen !== s + 11) $display("[TB] FAIL bubble_done got=%0d exp=%0d", done_seen, s + 11);
        else n_pass++;
`ifdef FEEDER_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd1) $display("[TB] FAIL bubble_stall got=%0d exp=1", stall_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_zero_len();
        int s, fire_seen, done_seen, ready_seen, lane_seen;
        s = cyc; fire_seen = -1; done_seen = -1; ready_seen = 0; lane_seen = 0;
        for (int t = 0; t < 6; t++) begin
            bus.start   = (t == 0);
            bus.k_len   = '0;
            bus.s_valid = 1'b1;
            for (int j = 0; j < COLS; j++) bus.s_w[j] = 8'($urandom);
            for (int i = 0; i < ROWS; i++) bus.s_a[i] = 8'($urandom);
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("[TB] FAIL zero_len cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (bus.fire === 1'b1 && fire_seen < 0) fire_seen = cyc;
            if (bus.done === 1'b1 && done_seen < 0) done_seen = cyc;
            if (bus.s_ready !== 1'b0) ready_seen++;
            if ({bus.out_w, bus.out_a} !== '0) lane_seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (done_seen !== s + 1) $display("[TB] FAIL zero_len_done got=%0d exp=%0d", done_seen, s + 1);
        else n_pass++;
        n_checks++;
        if (fire_seen !== -1) $display("[TB] FAIL zero_len_fire got=%0d exp=-1", fire_seen);
        else n_pass++;
        n_checks++;
        if (ready_seen !== 0) $display("[TB] FAIL zero_len_ready got=%0d exp=0", ready_seen);
        else n_pass++;
        n_checks++;
        if (lane_seen !== 0) $display("[TB] FAIL zero_len_lanes got=%0d exp=0", lane_seen);
        else n_pass++;
    endtask

    task automatic test_reset_flush();
        int s, b, done_seen;
        logic [VW-1:0] after_rst;
        s = cyc; b = 0; done_seen = -1; after_rst = '1;
        for (int t = 0; t < 22; t++) begin
            rst         = (t == 8);
            bus.start   = (t == 0) || (t == 10);
            bus.k_len   = (t == 10) ? KW'(1) : KW'(5);
            bus.s_valid = 1'b1;
            bus.s_w     = {COLS{8'(b + 1)}};
            bus.s_a     = {ROWS{8'(b + 1)}};
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("[TB] FAIL reset_flush cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (t == 9) after_rst = obs_vec;
            if (bus.done === 1'b1 && done_seen < 0) done_seen = cyc;
            if (exp_ready && bus.s_valid && !rst) b++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.s_valid = 1'b0;
        n_checks++;
        if (after_rst !== '0) $display("[TB] FAIL reset_flush_idle got=%h exp=0", after_rst);
        else n_pass++;
        n_checks++;
        if (done_seen !== s + 18) $display("[TB] FAIL reset_flush_done got=%0d exp=%0d", done_seen, s + 18);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int s, b, done_seen, done_count;
        s = cyc; b = 0; done_seen = -1; done_count = 0;
        for (int t = 0; t < 14; t++) begin
            bus.start   = (t == 0) || (t == 2);
            bus.k_len   = (t == 2) ? KW'(7) : KW'(2);
            bus.s_valid = 1'b1;
            bus.s_w     = {COLS{8'(8'h40 + b)}};
            bus.s_a     = {ROWS{8'(8'h80 + b)}};
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("[TB] FAIL start_ignored cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (bus.done === 1'b1) begin
                done_count++;
                if (done_seen < 0) done_seen = cyc;
            end
            if (exp_ready && bus.s_valid) b++;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        n_checks++;
        if (done_seen !== s + 9) $display("[TB] FAIL start_ignored_done got=%0d exp=%0d", done_seen, s + 9);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("[TB] FAIL start_ignored_count got=%0d exp=1", done_count);
        else n_pass++;
    endtask

    task automatic test_single_ff();
        int s, done_seen;
        logic [7:0] a1, w5, w5_early;
        s = cyc; done_seen = -1; a1 = '0; w5 = '0; w5_early = 8'h55;
        for (int t = 0; t < 10; t++) begin
            bus.start   = (t == 0);
            bus.k_len   = KW'(1);
            bus.s_valid = 1'b1;
            bus.s_w     = {COLS{8'hFF}};
            bus.s_a     = {ROWS{8'hFF}};
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) $display("[TB] FAIL single_ff cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            else n_pass++;
            if (t == 3) a1 = bus.out_a[1];
            if (t == 6) w5_early = bus.out_w[5];
            if (t == 7) w5 = bus.out_w[5];
            if (bus.done === 1'b1 && done_seen < 0) done_seen = cyc;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        n_checks++;
        if (a1 !== 8'hFF) $display("[TB] FAIL single_ff_a1 got=%h exp=ff", a1);
        else n_pass++;
        n_checks++;
        if (w5 !== 8'hFF) $display("[TB] FAIL single_ff_w5 got=%h exp=ff", w5);
        else n_pass++;
        n_checks++;
        if (w5_early !== 8'h00) $display("[TB] FAIL single_ff_w5_early got=%h exp=00", w5_early);
        else n_pass++;
        n_checks++;
        if (done_seen !== s + 8) $display("[TB] FAIL single_ff_done got=%0d exp=%0d", done_seen, s + 8);
        else n_pass++;
    endtask

    task automatic test_random();
        int k;
        bit finished;
        for (int n = 0; n < 14; n++) begin
            k = (n == 0) ? KMAX : (n == 1) ? 0 : int'($urandom_range(0, KMAX));
            finished = 1'b0;
            for (int t = 0; t < 150; t++) begin
                bus.start   = (t == 0) || ($urandom_range(0, 7) == 0);
                bus.k_len   = (t == 0) ? KW'(k) : KW'($urandom_range(0, KMAX));
                bus.s_valid = ($urandom_range(0, 3) != 0);
                for (int j = 0; j < COLS; j++) bus.s_w[j] = 8'($urandom);
                for (int i = 0; i < ROWS; i++) bus.s_a[i] = 8'($urandom);
                @(negedge clk);
                n_checks++;
                if (obs_vec !== exp_vec) $display("[TB] FAIL random tile=%0d cyc=%0d got=%h exp=%h", n, cyc, obs_vec, exp_vec);
                else n_pass++;
`ifdef FEEDER_STALL_CNT_EN
                n_checks++;
                if (stall_cnt !== exp_stall) $display("[TB] FAIL random_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, exp_stall);
                else n_pass++;
`endif
                @(posedge clk); #1;
                bus.start = 1'b0;
                if (m_phase == 0) begin
                    finished = 1'b1;
                    break;
                end
            end
            n_checks++;
            if (!finished) $display("[TB] FAIL random_timeout tile=%0d got=busy exp=idle", n);
            else n_pass++;
        end
        bus.s_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.k_len   = '0;
        bus.s_valid = 1'b0;
        bus.s_w     = '0;
        bus.s_a     = '0;
        test_reset();
        test_basic();
        test_bubble();
        test_zero_len();
        test_reset_flush();
        test_start_ignored();
        test_single_ff();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
